// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock with a start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN to honour signed_op; otherwise every divide is unsigned.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_ZERO = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             negQ_q, negQ_d;
  logic             negR_q, negR_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remOut_q, remOut_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] remNext, workNext;
  logic [WIDTH-1:0] qFix, rFix;
  logic [WIDTH-1:0] absA, absB;
  logic             negQIn, negRIn;

  // The partial remainder keeps the full remainder MSB so divisors above 2^(WIDTH-1) work.
  assign partial  = {rem_q, work_q[WIDTH-1]};
  assign trial    = partial - {1'b0, dvsr_q};
  assign remNext  = trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
  assign workNext = {work_q[WIDTH-2:0], ~trial[WIDTH]};

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign absA   = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
  assign absB   = (signed_op && divisor[WIDTH-1]) ? -divisor : divisor;
  assign negQIn = signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
  assign negRIn = signed_op && dividend[WIDTH-1];
  assign qFix   = negQ_q ? -workNext : workNext;
  assign rFix   = negR_q ? -remNext : remNext;
`else
  logic unused_signed;
  assign unused_signed = signed_op;
  assign absA   = dividend;
  assign absB   = divisor;
  assign negQIn = 1'b0;
  assign negRIn = 1'b0;
  assign qFix   = workNext;
  assign rFix   = remNext;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    negQ_d   = negQ_q;
    negR_d   = negR_q;
    quot_d   = quot_q;
    remOut_d = remOut_q;
    dbz_d    = dbz_q;
    done_d   = (state_q == S_DONE);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dbz_d  = 1'b0;
          rem_d  = '0;
          negQ_d = negQIn;
          negR_d = negRIn;
          dvsr_d = absB;
          if (divisor == '0) begin
            work_d  = dividend;
            state_d = S_ZERO;
          end else begin
            work_d  = absA;
            cnt_d   = CW'(WIDTH - 1);
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        rem_d  = remNext;
        work_d = workNext;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          quot_d   = qFix;
          remOut_d = rFix;
          state_d  = S_DONE;
        end
      end
      S_ZERO: begin
        quot_d   = '1;
        remOut_d = work_q;
        dbz_d    = 1'b1;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      quot_q   <= '0;
      remOut_q <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      negQ_q   <= negQ_d;
      negR_q   <= negR_d;
      quot_q   <= quot_d;
      remOut_q <= remOut_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remOut_q;
  assign div_by_zero = dbz_q;

endmodule
